simple_proc_arbiter: RTL

Shares the single `SimpleProcessor` datapath between `NREQ` requesters. The block accepts one 32-bit word at a time through a round-robin valid/ready front end and drives it onto the processor's `data_in`. After a fixed processor latency it samples `data_out` and returns the result, tagged with the requester index. It sits between the requester fabric and the `SimpleProcessor` instance and is the only driver of that instance's `data_in`.

---
 rtl/simple_proc_arbiter_if.sv | 32 +++
 rtl/simple_proc_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/simple_proc_arbiter_if.sv
`default_nettype none
//==========================================================================
// simple_proc_arbiter_if : requester, processor and response bundle | rev 1.0
//==========================================================================
interface simple_proc_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      proc_data_in;
    logic [WIDTH-1:0]      proc_data_out;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;
    logic                  busy;

    modport slave (
        input  req_valid, req_data, proc_data_out, rsp_ready,
        output req_ready, proc_data_in, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_data, proc_data_out, rsp_ready,
        input  req_ready, proc_data_in, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/simple_proc_arbiter.sv
`default_nettype none
//==========================================================================
// simple_proc_arbiter : round-robin sharing of one processor datapath | rev 1.0
//==========================================================================
module simple_proc_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    simple_proc_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] proc_data_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             gnt_found_d;
    logic [IDW-1:0]   gnt_idx_d;
    logic [NREQ-1:0]  gnt_onehot_d;
    logic [IDW-1:0]   ptr_d;

    // Descending scan so the candidate closest to ptr_q is the last writer.
    always_comb begin
        gnt_found_d  = 1'b0;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
        if (gnt_found_d) begin
            gnt_onehot_d[gnt_idx_d] = 1'b1;
        end
        ptr_d = (gnt_idx_d == IDW'(NREQ - 1)) ? '0 : gnt_idx_d + IDW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            proc_data_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found_d) begin
                        proc_data_q <= bus.req_data[gnt_idx_d*WIDTH +: WIDTH];
                        id_q        <= gnt_idx_d;
                        ptr_q       <= ptr_d;
                        cnt_q       <= CW'(LATENCY);
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rsp_data_q  <= bus.proc_data_out;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is masked while reset is held so no requester sees a ready.
    assign bus.req_ready    = (rst && state_q == IDLE) ? gnt_onehot_d : '0;
    assign bus.busy         = (state_q != IDLE);
    assign bus.proc_data_in = proc_data_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
endmodule
`default_nettype wire
